// File: rtl/path_delay_sequencer.sv
// Sweeps a bank of inverter delay paths: for each path, launches a transition, counts clock
// cycles until the synchronized output follows, sums 2^TRIALS_LOG2 trials, reports via valid/ready.
module path_delay_sequencer #(
    parameter int NUM_PATHS   = 8,
    parameter int CNT_W       = 12,
    parameter int TRIALS_LOG2 = 3,
    parameter int TIMEOUT     = 4000,
    parameter int SETTLE      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic [NUM_PATHS-1:0]            pathInputs,
    input  logic [NUM_PATHS-1:0]            pathResults,
    output logic                            busy,
    output logic                            done,
    output logic                            resValid,
    input  logic                            resReady,
    output logic [$clog2(NUM_PATHS)-1:0]    resPath,
    output logic [CNT_W+TRIALS_LOG2-1:0]    resSum,
    output logic                            resTimeout
);

    localparam int SEL_W = $clog2(NUM_PATHS);
    localparam int SUM_W = CNT_W + TRIALS_LOG2;
    localparam int SET_W = $clog2(SETTLE);

    localparam logic [CNT_W-1:0]       TIMEOUT_V   = CNT_W'(TIMEOUT);
    localparam logic [SET_W-1:0]       SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [SEL_W-1:0]       LAST_PATH   = SEL_W'(NUM_PATHS - 1);
    localparam logic [TRIALS_LOG2-1:0] LAST_TRIAL  = '1;

    // Result handshake: a result transfers on a rising edge where resValid && resReady;
    // resValid, resPath, resSum and resTimeout stay stable until that edge.
    typedef enum logic [2:0] {
        stIdle, stSettle, stLaunch, stMeasure, stAccum, stReport
    } state_t;

    state_t state, stateNext;

    logic [1:0]             rstSync;
    logic                   rstInt;
    logic [NUM_PATHS-1:0]   syncA, syncB;
    logic [SEL_W-1:0]       sel;
    logic [TRIALS_LOG2-1:0] trial;
    logic [SET_W-1:0]       settleCnt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       trialCnt;
    logic [SUM_W-1:0]       sum;
    logic [SUM_W-1:0]       sumNext;
    logic                   tflag;
    logic                   baseline;
    logic                   changed;

    // Reset asserts immediately but releases two clocks after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rstSync <= 2'b00;
        else        rstSync <= {rstSync[0], 1'b1};
    end
    assign rstInt = rstSync[1];

    always_ff @(posedge clk or negedge rstInt) begin
        if (!rstInt) begin
            syncA <= '0;
            syncB <= '0;
        end else begin
            syncA <= pathResults;
            syncB <= syncA;
        end
    end

    assign changed = (syncB[sel] != baseline);
    assign sumNext = sum + {{TRIALS_LOG2{1'b0}}, trialCnt};

    always_ff @(posedge clk or negedge rstInt) begin
        if (!rstInt) state <= stIdle;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            stIdle:    if (start) stateNext = stSettle;
            stSettle:  if (settleCnt == SETTLE_LAST) stateNext = stLaunch;
            stLaunch:  stateNext = stMeasure;
            stMeasure: if (changed || cnt == TIMEOUT_V) stateNext = stAccum;
            stAccum:   stateNext = (trial == LAST_TRIAL) ? stReport : stSettle;
            stReport:  if (resReady) stateNext = (sel == LAST_PATH) ? stIdle : stSettle;
            default:   stateNext = stIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstInt) begin
        if (!rstInt) begin
            pathInputs <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resValid   <= 1'b0;
            resPath    <= '0;
            resSum     <= '0;
            resTimeout <= 1'b0;
            sel        <= '0;
            trial      <= '0;
            settleCnt  <= '0;
            cnt        <= '0;
            trialCnt   <= '0;
            sum        <= '0;
            tflag      <= 1'b0;
            baseline   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                stIdle: begin
                    if (start) begin
                        busy      <= 1'b1;
                        sel       <= '0;
                        trial     <= '0;
                        sum       <= '0;
                        tflag     <= 1'b0;
                        settleCnt <= '0;
                    end
                end
                stSettle: begin
                    settleCnt <= settleCnt + 1'b1;
                    if (settleCnt == SETTLE_LAST) baseline <= syncB[sel];
                end
                stLaunch: begin
                    pathInputs[sel] <= ~pathInputs[sel];
                    cnt             <= '0;
                end
                stMeasure: begin
                    // A change seen on the timeout cycle still counts as a real edge.
                    if (changed) begin
                        trialCnt <= cnt;
                    end else if (cnt == TIMEOUT_V) begin
                        trialCnt <= TIMEOUT_V;
                        tflag    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                stAccum: begin
                    sum       <= sumNext;
                    trial     <= trial + 1'b1;
                    settleCnt <= '0;
                    if (trial == LAST_TRIAL) begin
                        resValid   <= 1'b1;
                        resPath    <= sel;
                        resSum     <= sumNext;
                        resTimeout <= tflag;
                    end
                end
                stReport: begin
                    if (resReady) begin
                        resValid  <= 1'b0;
                        settleCnt <= '0;
                        if (sel == LAST_PATH) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            sel   <= sel + 1'b1;
                            sum   <= '0;
                            tflag <= 1'b0;
                            trial <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_sequencer.sv
// Bench for path_delay_sequencer: models each delay path as a cycle-delayed or stuck loopback
// and predicts per-path sums from trial-count arithmetic.
module tb_path_delay_sequencer;

    localparam int NP      = 8;
    localparam int CNT_W   = 12;
    localparam int TL      = 3;
    localparam int TIMEOUT = 4000;
    localparam int SETTLE  = 16;
    localparam int NTRIALS = 1 << TL;
    localparam int SUM_W   = CNT_W + TL;
    localparam int RW      = 3 + SUM_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [NP-1:0]    pathInputs;
    logic [NP-1:0]    pathResults;
    logic             busy, done, resValid, resReady;
    logic [2:0]       resPath;
    logic [SUM_W-1:0] resSum;
    logic             resTimeout;

    int checks = 0;
    int failures = 0;

    logic [RW-1:0] exp_q[$];

    // Path model configuration
    int      delay[NP];
    int      firstDelay[NP];
    bit      stuck[NP];
    bit      firstPending[NP];
    bit      pend[NP];
    int      due[NP];
    logic [NP-1:0] prevIn;
    logic [NP-1:0] pathRes;
    int      cycNo;

    path_delay_sequencer #(
        .NUM_PATHS(NP), .CNT_W(CNT_W), .TRIALS_LOG2(TL), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pathInputs(pathInputs), .pathResults(pathResults),
        .busy(busy), .done(done), .resValid(resValid), .resReady(resReady),
        .resPath(resPath), .resSum(resSum), .resTimeout(resTimeout)
    );

    always #5 clk = ~clk;

    // A path with delay D presents a toggle of its input D clock edges later.
    always @(posedge clk) begin
        if (!rst_n) begin
            cycNo  = 0;
            prevIn = '0;
            for (int i = 0; i < NP; i++) begin
                pend[i]    = 1'b0;
                pathRes[i] <= 1'b0;
            end
        end else begin
            cycNo++;
            for (int i = 0; i < NP; i++) begin
                if (pathInputs[i] !== prevIn[i]) begin
                    int d;
                    prevIn[i] = pathInputs[i];
                    d = firstPending[i] ? firstDelay[i] : delay[i];
                    firstPending[i] = 1'b0;
                    if (d <= 1) pathRes[i] <= pathInputs[i];
                    else begin
                        pend[i] = 1'b1;
                        due[i]  = cycNo + d - 1;
                    end
                end else if (pend[i] && cycNo == due[i]) begin
                    pathRes[i] <= prevIn[i];
                    pend[i] = 1'b0;
                end else if (!pend[i]) begin
                    pathRes[i] <= prevIn[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++)
            pathResults[i] = stuck[i] ? 1'b0 :
                             ((delay[i] == 0 && !firstPending[i]) ? pathInputs[i] : pathRes[i]);
    end

    task automatic clear_paths();
        for (int i = 0; i < NP; i++) begin
            delay[i] = 0; firstDelay[i] = 0; stuck[i] = 1'b0; firstPending[i] = 1'b0;
        end
    endtask

    // Predicted per-trial count is 2 cycles of synchronizer plus the path delay, capped at TIMEOUT.
    task automatic push_expected();
        for (int i = 0; i < NP; i++) begin
            int total, d, c;
            bit to;
            total = 0; to = 1'b0;
            for (int k = 0; k < NTRIALS; k++) begin
                d = (k == 0 && firstPending[i]) ? firstDelay[i] : delay[i];
                if (stuck[i] || 2 + d > TIMEOUT) begin
                    c = TIMEOUT; to = 1'b1;
                end else begin
                    c = 2 + d;
                end
                total += c;
            end
            exp_q.push_back({3'(i), SUM_W'(total), to});
        end
    endtask

    task automatic run_sweep(input bit randReady, input bit holdFirst, input bit pokeStart,
                             input int budget);
        int cyc;
        bit doneSeen, held;
        int extraDone;
        logic [RW-1:0] got, exp, snap;
        logic [NP-1:0] pinSnap;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL busy_accept: got %b expected 1", busy);
        end
        cyc = 0; doneSeen = 1'b0; held = 1'b0;
        while (!doneSeen && cyc < budget) begin
            if (holdFirst && !held && resValid === 1'b1) begin
                resReady = 1'b0;
                snap    = {resPath, resSum, resTimeout};
                pinSnap = pathInputs;
                repeat (20) begin
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (resValid !== 1'b1 || {resPath, resSum, resTimeout} !== snap ||
                        pathInputs !== pinSnap) begin
                        failures++;
                        $display("FAIL hold_stable: got v=%b res=%h pin=%h expected v=1 res=%h pin=%h",
                                 resValid, {resPath, resSum, resTimeout}, pathInputs, snap, pinSnap);
                    end
                end
                held = 1'b1;
            end
            resReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = (pokeStart && cyc == 100);
            if (done === 1'b1) begin
                doneSeen = 1'b1;
                checks++;
                if (busy !== 1'b0 || exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL done_state: got busy=%b pending=%0d expected busy=0 pending=0",
                             busy, exp_q.size());
                end
            end else if (resValid === 1'b1 && resReady) begin
                got = {resPath, resSum, resTimeout};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL result_extra: got %h expected none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL result: got path=%0d sum=%0d to=%b expected path=%0d sum=%0d to=%b",
                                 resPath, resSum, resTimeout, exp[RW-1 -: 3], exp[SUM_W:1], exp[0]);
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        resReady = 1'b0;
        if (!doneSeen) begin
            checks++; failures++;
            $display("FAIL sweep_timeout: got no done in %0d cycles expected done", budget);
            exp_q.delete();
        end
        extraDone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extraDone++;
        end
        checks++;
        if (extraDone != 0) begin
            failures++; $display("FAIL after_done: got %0d bad cycles expected 0", extraDone);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({pathInputs, busy, done, resValid, resPath, resSum, resTimeout} !== '0) begin
            failures++;
            $display("FAIL %s: got pin=%h busy=%b done=%b v=%b path=%0d sum=%0d to=%b expected all 0",
                     name, pathInputs, busy, done, resValid, resPath, resSum, resTimeout);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; resReady = 1'b0;
        clear_paths();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_loopback();
        clear_paths();
        push_expected();
        run_sweep(1'b0, 1'b0, 1'b0, 5000);
    endtask

    task automatic test_path_delay();
        clear_paths();
        delay[3] = 5;
        push_expected();
        run_sweep(1'b1, 1'b0, 1'b0, 6000);
    endtask

    task automatic test_back_pressure();
        clear_paths();
        push_expected();
        run_sweep(1'b0, 1'b1, 1'b0, 5000);
    endtask

    task automatic test_timeout();
        clear_paths();
        stuck[5] = 1'b1;
        delay[6] = 1;
        firstDelay[6] = TIMEOUT - 2;
        firstPending[6] = 1'b1;
        push_expected();
        run_sweep(1'b0, 1'b0, 1'b1, 45000);
        clear_paths();
    endtask

    task automatic test_reset_mid_sweep();
        int got, cyc;
        clear_paths();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        resReady = 1'b1;
        got = 0; cyc = 0;
        while (!(got >= 2 && pathInputs[2] === 1'b1) && cyc < 3000) begin
            if (resValid === 1'b1) begin
                checks++;
                if (resPath !== 3'(got) || resSum !== SUM_W'(2 * NTRIALS) || resTimeout !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_result: got path=%0d sum=%0d to=%b expected path=%0d sum=%0d to=0",
                             resPath, resSum, resTimeout, got, 2 * NTRIALS);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 3000) begin
            failures++; $display("FAIL mid_reach: got %0d results expected path 2 launch", got);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_sweep_reset");
        resReady = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("mid_sweep_idle");
        push_expected();
        run_sweep(1'b0, 1'b0, 1'b0, 5000);
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            clear_paths();
            for (int i = 0; i < NP; i++) delay[i] = $urandom_range(0, 12);
            push_expected();
            run_sweep(1'b1, 1'b0, 1'b0, 8000);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_path_delay();
        test_back_pressure();
        test_timeout();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
